// File: rtl/lbm_moment_ram_pkg.sv
// ---------------------------------------------------------------------------
// lbm_moment_ram_pkg
//   Shared definitions for the LBM moment storage.
//   - LAT_X / LAT_Y : lattice dimensions (nodes per axis)
//   - LAT_NODES     : total node count, one stored moment per node
//   - MOMENT_W      : moment word width
//   - moment_t      : two's-complement moment word
//   - ram_state_e   : clear-sweep / normal-access states of the moment RAM
// ---------------------------------------------------------------------------
package lbm_moment_ram_pkg;

  localparam int LAT_X     = 16;
  localparam int LAT_Y     = 16;
  localparam int LAT_NODES = LAT_X * LAT_Y;
  localparam int MOMENT_W  = 32;

  typedef logic signed [MOMENT_W-1:0] moment_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_e;

endpackage

// File: rtl/lbm_bram_sp.sv
// ---------------------------------------------------------------------------
// lbm_bram_sp
//   Single-port inferable block RAM, synchronous write, registered read,
//   write-first on a simultaneous read/write. No reset on the array or on the
//   read register so the storage maps cleanly onto a vendor block RAM.
//   Ports:
//     clk   in   1     clock
//     we    in   1     write enable
//     addr  in   AW    word address
//     din   in   DW    write data
//     dout  out  DW    registered read data (1-cycle latency)
// ---------------------------------------------------------------------------
module lbm_bram_sp #(
  parameter int DEPTH         = 256,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write-first: the word being written is also what the read port returns.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/lbm_moment_ram.sv
// ---------------------------------------------------------------------------
// lbm_moment_ram
//   One signed macroscopic moment (rho, ux, uy, ...) per lattice node, stored
//   in a single-port block RAM with a registered read. After reset an internal
//   sweep writes zero to every word; ready rises once the sweep is done and
//   stays high until the next reset.
//   Ports:
//     Clk       in   1              clock, rising edge
//     Reset_n   in   1              asynchronous active-low reset
//     address   in   ADDRESS_WIDTH  word address (>= DEPTH: no write, reads 0)
//     WE        in   1              write enable
//     data_in   in   DATA_WIDTH     signed write data
//     data_out  out  DATA_WIDTH     signed registered read data
//     ready     out  1              clear sweep finished
// ---------------------------------------------------------------------------
module lbm_moment_ram
  import lbm_moment_ram_pkg::*;
#(
  parameter int DEPTH         = LAT_NODES,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH    = MOMENT_W
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic [ADDRESS_WIDTH-1:0]     address,
  input  logic                         WE,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         ready
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  ram_state_e               state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;
  // Forces data_out to zero for the cycle following a clear-sweep edge or an
  // out-of-range access; reset sets it so data_out drops to 0 asynchronously.
  logic                     zero_out_reg, zero_out_next;

  logic                     in_range;
  logic                     ram_we;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_din;
  logic [DATA_WIDTH-1:0]    ram_dout;

  // When DEPTH fills the address space every address is valid; only build the
  // comparator when some addresses can actually fall outside the array.
  generate
    if (DEPTH == (1 << ADDRESS_WIDTH)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_partial_range
      assign in_range = (address < ADDRESS_WIDTH'(DEPTH));
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= ST_CLEAR;
      clr_cnt_reg  <= '0;
      zero_out_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      zero_out_reg <= zero_out_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_cnt_next  = clr_cnt_reg;
    zero_out_next = 1'b1;
    ram_we        = 1'b0;
    ram_addr      = address;
    ram_din       = data_in;

    case (state_reg)
      ST_CLEAR: begin
        // Sweep owns the RAM port; user inputs are ignored.
        ram_we       = 1'b1;
        ram_addr     = clr_cnt_reg;
        ram_din      = '0;
        clr_cnt_next = clr_cnt_reg + ADDRESS_WIDTH'(1);
        if (clr_cnt_reg == LAST_ADDR) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        ram_we        = WE & in_range;
        zero_out_next = ~in_range;
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
  end

  lbm_bram_sp #(
    .DEPTH         (DEPTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_bram (
    .clk  (Clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  assign data_out = zero_out_reg ? '0 : ram_dout;
  assign ready    = (state_reg == ST_RUN);

endmodule

// File: tb/tb_lbm_moment_ram.sv
// ---------------------------------------------------------------------------
// tb_lbm_moment_ram
//   Self-checking bench for lbm_moment_ram. A behavioural model (plain array
//   plus an edge counter since reset release) predicts data_out and ready for
//   every clock edge; directed sequences and random traffic run through it.
// ---------------------------------------------------------------------------
module tb_lbm_moment_ram;
  import lbm_moment_ram_pkg::*;

  localparam int DEPTH = LAT_NODES;

  logic       Clk     = 1'b0;
  logic       Reset_n = 1'b0;
  logic       WE      = 1'b0;
  logic [7:0] address = '0;
  moment_t    data_in = '0;
  moment_t    data_out;
  logic       ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_mem [DEPTH];
  int          edges_since_release = 0;

  always #5 Clk = ~Clk;

  lbm_moment_ram dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .address  (address),
    .WE       (WE),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge of traffic. The model decides the expected output from
  // whether the sweep is finished (256 edges since release) before this edge.
  task automatic op(input string tag, input logic [7:0] a, input logic we, input logic [31:0] d);
    logic [31:0] exp_data;
    logic        was_run;
    logic        exp_ready;
    address  = a;
    WE       = we;
    data_in  = d;
    was_run  = (edges_since_release >= DEPTH);
    exp_data = '0;
    if (was_run) begin
      if (we) begin
        model_mem[a] = d;
        exp_data     = d;
      end else begin
        exp_data = model_mem[a];
      end
    end
    @(posedge Clk);
    #1;
    edges_since_release++;
    exp_ready = (edges_since_release >= DEPTH);
    check({tag, "_data"}, data_out, exp_data);
    check({tag, "_rdy"}, {31'b0, ready}, {31'b0, exp_ready});
    $display("[TB] %s a=%02h we=%0d din=%h -> dout=%h rdy=%0d", tag, a, we, d, data_out, ready);
  endtask

  // Asserts reset away from the clock edge, checks the asynchronous effect,
  // holds for two edges and releases just after an edge.
  task automatic do_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    check("rst_data", data_out, 32'h0);
    check("rst_rdy", {31'b0, ready}, 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    edges_since_release = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    $display("[TB] reset released");
  endtask

  task automatic clear_phase(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      op(tag, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  initial begin
    // 1: reset, sweep length, data_out held at 0 with user traffic ignored
    #1;
    do_reset();
    clear_phase("clr");

    // 2: fresh memory reads zero
    for (int i = 0; i < 4; i++) op("rd0", 8'(i), 1'b0, $urandom);

    // 3: two writes and readback
    op("w3a", 8'h00, 1'b1, 32'h1234_5678);
    op("w3b", 8'h12, 1'b1, 32'hABCC_CDEF);
    op("r3a", 8'h00, 1'b0, 32'h0);
    op("r3b", 8'h12, 1'b0, 32'h0);

    // 4: write-first burst, then readback
    for (int i = 0; i < 4; i++) op("wf4", 8'(i), 1'b1, 32'h1);
    for (int i = 0; i < 4; i++) op("rb4", 8'(i), 1'b0, 32'h0);

    // 5: extreme signed values at the top address
    op("w5min", 8'hFF, 1'b1, 32'h8000_0000);
    op("r5min", 8'hFF, 1'b0, 32'h0);
    op("w5neg", 8'hFF, 1'b1, 32'hFFFF_FFFF);
    op("r5neg", 8'hFF, 1'b0, 32'h0);
    op("r5a0",  8'h00, 1'b0, 32'h0);

    // random traffic, biased to a small window so reads hit written words
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      op("rnd", a, 1'($urandom_range(0, 1)), $urandom);
    end

    // 6: reset in the middle of a write burst, then everything reads 0
    for (int i = 0; i < 6; i++) op("w6", 8'(8'h40 + i), 1'b1, $urandom | 32'h1);
    do_reset();
    clear_phase("clr6");
    for (int i = 0; i < 6; i++)  op("r6", 8'(8'h40 + i), 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) op("r6lo", 8'(i), 1'b0, 32'h0);
    op("r6ff", 8'hFF, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
